// File: rtl/issue_queue_ctrl.sv
// issue_queue_ctrl: in-order circular instruction buffer between the fetcher
// and the decoder. The head entry is dispatched only when its destination
// unit (LSB for loads/stores, RS otherwise) and the ROB can both accept it.
module issue_queue_ctrl #(
  parameter int IQ_WIDTH   = 2,
  parameter int STALL_BITS = 16
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  rob_clear_in,
  input  logic                  fetch_valid_in,
  input  logic [31:0]           fetch_ins_in,
  input  logic [31:0]           fetch_pc_in,
  output logic                  iq_full_out,
  input  logic                  rob_full_in,
  input  logic                  rs_full_in,
  input  logic                  lsb_full_in,
  output logic                  decoder_enable,
  output logic [31:0]           decoder_ins,
  output logic [31:0]           decoder_pc,
  output logic [STALL_BITS-1:0] stall_cnt
);

  localparam int IQ_DEPTH = 1 << IQ_WIDTH;
  localparam logic [IQ_WIDTH:0] FULL_COUNT = (IQ_WIDTH + 1)'(IQ_DEPTH);

  logic [IQ_WIDTH-1:0] head;
  logic [IQ_WIDTH-1:0] tail;
  logic [IQ_WIDTH:0]   count;
  logic [31:0]         ins_q [IQ_DEPTH];
  logic [31:0]         pc_q  [IQ_DEPTH];

  logic       not_empty;
  logic [6:0] head_op;
  logic       is_mem;
  logic       can_issue;
  logic       active;
  logic       enq;
  logic       deq;
  logic       stall_cond;

  // Head decode, dispatch/enqueue qualification and decoder-facing outputs
  always_comb begin
    not_empty      = (count != '0);
    head_op        = ins_q[head][6:0];
    is_mem         = (head_op == 7'b0000011) || (head_op == 7'b0100011);
    can_issue      = not_empty && !rob_full_in &&
                     (is_mem ? !lsb_full_in : !rs_full_in);
    active         = rdy_in && !rob_clear_in;
    iq_full_out    = (count == FULL_COUNT);
    decoder_enable = active && can_issue;
    enq            = active && fetch_valid_in && !iq_full_out;
    deq            = decoder_enable;
    stall_cond     = active && not_empty && !can_issue;
    decoder_ins    = not_empty ? ins_q[head] : '0;
    decoder_pc     = not_empty ? pc_q[head]  : '0;
  end

  // Pointer, occupancy and stall-counter state; flush keeps stall_cnt
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      stall_cnt <= '0;
    end else if (rdy_in) begin
      if (rob_clear_in) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (enq) tail <= tail + 1'b1;
        if (deq) head <= head + 1'b1;
        count <= count + (IQ_WIDTH + 1)'(enq) - (IQ_WIDTH + 1)'(deq);
      end
      if (stall_cond && (stall_cnt != '1))
        stall_cnt <= stall_cnt + STALL_BITS'(1);
    end
  end

  // Entry storage; contents are don't-care outside the occupied window
  always_ff @(posedge clk_in) begin
    if (!rst_in && enq) begin
      ins_q[tail] <= fetch_ins_in;
      pc_q[tail]  <= fetch_pc_in;
    end
  end

endmodule
